// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   lsu_state_e  - FSM state encoding of load_store_unit
//   F3_*         - RISC-V funct3 width/sign codes for loads and stores
//   DATA_W       - data path width (one memory word)
package lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_READ,
    RMW_WRITE,
    RESP
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Word-aligned byte address of the word containing addr.
  function automatic logic [31:0] word_addr(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for sub-word accesses.
//   funct3      - width/sign code of the access
//   byte_off    - address bits [1:0] of the access
//   mem_word    - full word read from data memory
//   store_data  - right-aligned store data
//   load_data   - selected byte/halfword/word, sign- or zero-extended
//   merged_word - mem_word with the addressed lanes replaced by store_data
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] mem_word,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word
);

  logic [4:0]        bit_shift;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] lane_data;

  assign bit_shift = {byte_off, 3'b000};
  assign shifted   = mem_word >> bit_shift;

  always_comb begin
    load_data = shifted;
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'd0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (funct3[1:0])
      2'b00:   lane_mask = 32'h0000_00FF << bit_shift;
      2'b01:   lane_mask = 32'h0000_FFFF << bit_shift;
      default: lane_mask = '1;
    endcase
  end

  assign lane_data   = store_data << bit_shift;
  assign merged_word = (mem_word & ~lane_mask) | (lane_data & lane_mask);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: executes one RISC-V load or store at a time against a
// single-cycle word-wide data memory. Sub-word stores are read-modify-write.
//   clk, reset_n          - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake (ready only when idle)
//   req_write, req_funct3 - operation and width/sign code
//   req_addr, req_wdata   - byte address and right-aligned store data
//   resp_valid            - one-cycle completion pulse
//   resp_rdata/resp_fault - extended load data / fault flag
//   mem_*                 - word-addressed data memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  lsu_state_e        state;
  logic              accept;
  logic              req_fault;
  logic [31:0]       addr_p0;
  logic [2:0]        funct3_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_word;

  function automatic logic fault_check(input logic       write,
                                       input logic [2:0]  funct3,
                                       input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    logic out_of_range;
    if (write)
      illegal = !(funct3 inside {F3_B, F3_H, F3_W});
    else
      illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned   = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                   ((funct3 == F3_W) && (addr[1:0] != 2'b00));
    out_of_range = ({1'b0, addr} >= ADDR_LIMIT);
    return illegal || misaligned || out_of_range;
  endfunction

  assign accept    = req_valid && req_ready;
  assign req_fault = fault_check(req_write, req_funct3, req_addr);

  // Request capture: data only, loaded at acceptance and held until the next.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0   <= req_addr;
      funct3_p0 <= req_funct3;
      wdata_p0  <= req_wdata;
    end
  end

  lsu_align u_align (
    .funct3      (funct3_p0),
    .byte_off    (addr_p0[1:0]),
    .mem_word    (mem_read_data),
    .store_data  (wdata_p0),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Control FSM with registered outputs; strobes and response fields default
  // to 0 every cycle so each is a single-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
    end else begin
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              mem_address <= word_addr(req_addr);
              if (!req_write) begin
                state    <= LOAD;
                mem_read <= 1'b1;
              end else if (req_funct3 == F3_W) begin
                state          <= STORE;
                mem_write      <= 1'b1;
                mem_write_data <= req_wdata;
              end else begin
                state    <= RMW_READ;
                mem_read <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        STORE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        // The read word is merged and issued as the write on the same edge.
        RMW_READ: begin
          state          <= RMW_WRITE;
          mem_write      <= 1'b1;
          mem_address    <= word_addr(addr_p0);
          mem_write_data <= merged_word;
        end
        RMW_WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized load/store requests against a
// byte-level reference memory; the DUT talks to a word-array memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] tb_mem [0:255];
  logic [7:0]  ref_b  [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(256)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_fault     (resp_fault),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = tb_mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_address[9:2]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int byte_addr);
    int base;
    base = byte_addr & ~3;
    return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
  endfunction

  // Issue one request and check everything it should produce.
  task automatic run_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input string tag, output logic [31:0] rdata_o);
    logic        flt;
    logic [31:0] exp_rd, exp_wd, val;
    int          nb, ai, exp_resp, exp_rdc, exp_wrc, exp_wr_at;
    int          n_rd, n_wr, n_rsp, rd_at, wr_at, rsp_at, bad, b;
    logic [31:0] got_rd, got_addr_r, got_addr_w, got_wd;
    logic        got_flt, rdy_after;

    nb = 1 << f3[1:0];
    if (w) flt = (f3 > 3'd2);
    else   flt = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    if (f3[1:0] == 2'd1 && a[0]) flt = 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) flt = 1'b1;
    if (a >= 32'd1024) flt = 1'b1;

    exp_rd = 0; exp_wd = 0; exp_wr_at = 0;
    if (flt) begin
      exp_resp = 1; exp_rdc = 0; exp_wrc = 0;
    end else if (!w) begin
      exp_resp = 2; exp_rdc = 1; exp_wrc = 0;
      ai  = int'(a);
      val = 0;
      for (int i = 0; i < nb; i++) val = val + (32'(ref_b[ai+i]) << (8*i));
      if (!f3[2] && nb < 4 && val[8*nb-1]) val = val - (32'd1 << (8*nb));
      exp_rd = val;
    end else begin
      ai = int'(a);
      exp_resp  = (nb == 4) ? 2 : 3;
      exp_rdc   = (nb == 4) ? 0 : 1;
      exp_wrc   = 1;
      exp_wr_at = (nb == 4) ? 1 : 2;
      for (int i = 0; i < nb; i++) ref_b[ai+i] = wd[8*i +: 8];
      exp_wd = ref_word(ai);
    end

    @(negedge clk);
    b = 0;
    while (!req_ready && b < 20) begin @(negedge clk); b++; end
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;

    n_rd = 0; n_wr = 0; n_rsp = 0; rd_at = 0; wr_at = 0; rsp_at = 0; bad = 0;
    got_rd = 0; got_addr_r = 0; got_addr_w = 0; got_wd = 0; got_flt = 0; rdy_after = 0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_read)   begin n_rd++;  rd_at = c;  got_addr_r = mem_address; end
      if (mem_write)  begin n_wr++;  wr_at = c;  got_addr_w = mem_address; got_wd = mem_write_data; end
      if (resp_valid) begin n_rsp++; rsp_at = c; got_rd = resp_rdata; got_flt = resp_fault; end
      if (c == exp_resp + 1) rdy_after = req_ready;
      if ((mem_read && mem_write) ||
          (!mem_read && !mem_write && mem_address != 0) ||
          (!mem_write && mem_write_data != 0) ||
          (!resp_valid && (resp_rdata != 0 || resp_fault))) bad++;
      @(negedge clk);
    end

    chk({tag, ".n_resp"},  32'(n_rsp),   32'd1);
    chk({tag, ".resp_at"}, 32'(rsp_at),  32'(exp_resp));
    chk({tag, ".fault"},   32'(got_flt), 32'(flt));
    chk({tag, ".rdata"},   got_rd,       exp_rd);
    chk({tag, ".n_read"},  32'(n_rd),    32'(exp_rdc));
    chk({tag, ".n_write"}, 32'(n_wr),    32'(exp_wrc));
    if (exp_rdc == 1) begin
      chk({tag, ".read_at"},   32'(rd_at), 32'd1);
      chk({tag, ".read_addr"}, got_addr_r, {a[31:2], 2'b00});
    end
    if (exp_wrc == 1) begin
      chk({tag, ".write_at"},   32'(wr_at), 32'(exp_wr_at));
      chk({tag, ".write_addr"}, got_addr_w, {a[31:2], 2'b00});
      chk({tag, ".write_data"}, got_wd,     exp_wd);
    end
    chk({tag, ".ready_after"}, 32'(rdy_after), 32'd1);
    chk({tag, ".idle_zero"},   32'(bad),       32'd0);
    rdata_o = got_rd;
  endtask

  initial begin
    logic [31:0] r, w32, a;
    logic [2:0]  f3;
    logic        wr;
    int          n_wr, n_rsp, diff;
    logic [2:0]  legal_ld [0:4];
    logic [2:0]  legal_st [0:2];

    legal_ld[0] = 3'b000; legal_ld[1] = 3'b001; legal_ld[2] = 3'b010;
    legal_ld[3] = 3'b100; legal_ld[4] = 3'b101;
    legal_st[0] = 3'b000; legal_st[1] = 3'b001; legal_st[2] = 3'b010;

    for (int i = 0; i < 256; i++) begin
      w32 = (i == 4) ? 32'h8899AABB : $urandom;
      tb_mem[i] <= w32;
      for (int k = 0; k < 4; k++) ref_b[4*i+k] = w32[8*k +: 8];
    end

    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = 0; req_wdata = 0;
    #2;
    chk("reset.ctrl", {27'd0, req_ready, mem_read, mem_write, resp_valid, resp_fault}, 32'd0);
    chk("reset.addr",  mem_address,    32'd0);
    chk("reset.wdata", mem_write_data, 32'd0);
    chk("reset.rdata", resp_rdata,     32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset.ready_after", 32'(req_ready), 32'd1);

    // Sub-word loads from word 0x10
    run_req(1'b0, 3'b000, 32'h13, 32'h0, "lb_13", r);
    chk("lb_13.value", r, 32'hFFFFFF88);
    run_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13", r);
    chk("lbu_13.value", r, 32'h00000088);
    run_req(1'b0, 3'b001, 32'h10, 32'h0, "lh_10", r);
    chk("lh_10.value", r, 32'hFFFFAABB);

    // Halfword read-modify-write, then read back
    run_req(1'b1, 3'b001, 32'h12, 32'h00001234, "sh_12", r);
    run_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10", r);
    chk("lw_10.value", r, 32'h1234AABB);

    // Full-word store and read back
    run_req(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, "sw_20", r);
    run_req(1'b0, 3'b010, 32'h20, 32'h0, "lw_20", r);
    chk("lw_20.value", r, 32'hDEADBEEF);

    // Faults: misaligned, out of range, illegal funct3
    run_req(1'b0, 3'b010, 32'h22,  32'h0, "lw_22_fault", r);
    run_req(1'b1, 3'b000, 32'h400, 32'hFF, "sb_400_fault", r);
    run_req(1'b0, 3'b101, 32'h11,  32'h0, "lhu_11_fault", r);
    run_req(1'b1, 3'b100, 32'h40,  32'h0, "st_f3_fault", r);
    run_req(1'b0, 3'b011, 32'h40,  32'h0, "ld_f3_fault", r);
    run_req(1'b0, 3'b000, 32'h3FF, 32'h0, "lb_last", r);

    // Reset while the read half of a byte RMW is in flight
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h31; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_rmw.in_read", 32'(mem_read), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_rmw.ctrl", {27'd0, req_ready, mem_read, mem_write, resp_valid, resp_fault}, 32'd0);
    chk("rst_rmw.addr", mem_address, 32'd0);
    chk("rst_rmw.wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    n_wr = 0; n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_write)  n_wr++;
      if (resp_valid) n_rsp++;
    end
    chk("rst_rmw.no_write", 32'(n_wr),  32'd0);
    chk("rst_rmw.no_resp",  32'(n_rsp), 32'd0);
    chk("rst_rmw.ready",    32'(req_ready), 32'd1);
    chk("rst_rmw.mem",      tb_mem[12], ref_word(32'h30));

    // Randomized requests
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom);
      if ($urandom_range(0, 9) < 8)
        f3 = wr ? legal_st[$urandom_range(0, 2)] : legal_ld[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom);
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1024, 1100))
                                      : 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      run_req(wr, f3, a, $urandom, $sformatf("rand%0d", n), r);
    end

    diff = 0;
    for (int i = 0; i < 256; i++) if (tb_mem[i] !== ref_word(4*i)) diff++;
    chk("final.mem_words_differ", 32'(diff), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 256, depth in words of the downstream data memory.
REQ-002 SHALL have ports, one per line:
  clk  input  1  single clock; all state updates on rising edge
  reset_n  input  1  reset, asynchronous, active-low
  req_valid  input  1  execute stage presents a load/store request
  req_ready  output  1  unit can accept a request this cycle
  req_write  input  1  1 = store, 0 = load
  req_funct3  input  3  RISC-V width/sign code: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010
  req_addr  input  32  byte address
  req_wdata  input  32  store data, right-aligned
  resp_valid  output  1  one-cycle pulse: request complete
  resp_rdata  output  32  extended load data; 0 for stores and faults
  resp_fault  output  1  request misaligned, out of range or illegal funct3
  mem_read  output  1  to data memory read enable
  mem_write  output  1  to data memory write enable
  mem_address  output  32  to data memory word address, bits [1:0] = 0
  mem_write_data  output  32  to data memory full-word write data
  mem_read_data  input  32  from data memory; combinational, valid in same cycle as mem_read

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, STORE, RMW_READ, RMW_WRITE, RESP.
REQ-004 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-005 SHALL capture all req_* fields at acceptance; later changes to them SHALL have no effect.
REQ-006 On acceptance, a fault SHALL be detected when: funct3 illegal for the operation; halfword with addr[0]=1; word with addr[1:0]!=0; or addr >= 4*MEM_WORDS.
REQ-007 Faulted request: IDLE->RESP, with no mem_read or mem_write; resp_fault=1, resp_rdata=0; resp_valid 1 cycle after acceptance.
REQ-008 Load: IDLE->LOAD->RESP. In LOAD, mem_read=1. Byte/halfword selected by addr[1:0], then sign- or zero-extended per funct3 and registered. resp_valid 2 cycles after acceptance.
REQ-009 SW: IDLE->STORE->RESP. In STORE, mem_write=1 and mem_write_data=req_wdata. resp_valid 2 cycles after acceptance.
REQ-010 SB/SH: IDLE->RMW_READ->RMW_WRITE->RESP.
  - RMW_READ: mem_read=1; word captured.
  - RMW_WRITE: mem_write=1 with merged word; only the addressed byte/halfword lanes replaced by low bits of req_wdata.
  - resp_valid 3 cycles after acceptance.
REQ-011 mem_address SHALL equal {captured addr[31:2], 2'b00} while mem_read or mem_write is 1, and 0 otherwise.
REQ-012 mem_read and mem_write SHALL never be 1 together; each SHALL be 1 for exactly one cycle per access.
REQ-013 mem_write_data SHALL be 0 when mem_write=0.
REQ-014 RESP SHALL last one cycle, then return to IDLE; resp_valid has no backpressure.
REQ-015 resp_rdata and resp_fault SHALL be 0 whenever resp_valid=0.
REQ-016 A new request SHALL be acceptable in the cycle after RESP; back-to-back throughput = one request per latency+1 cycles.

Reset
REQ-017 On reset_n low, asynchronously: state=IDLE; all outputs 0, except req_ready=1 after release.
REQ-018 Reset during RMW_READ SHALL prevent the pending write; memory contents SHALL be untouched.
REQ-019 No response SHALL be issued for a request interrupted by reset.

Structure
REQ-020 Package lsu_pkg SHALL hold the FSM state enum and the funct3 encoding constants.
REQ-021 Byte/halfword extraction, extension and store merge SHALL be in one combinational sub-module, lsu_align. The FSM and registers SHALL be in load_store_unit.

Verification
REQ-022 Memory word 0x10 = 0x8899AABB; LB addr 0x13 -> mem_read one cycle; resp_rdata=0xFFFFFF88 at acceptance+2; LBU -> 0x00000088.
REQ-023 SH addr 0x12, wdata 0x00001234, memory word 0x8899AABB -> read at +1, write 0x1234AABB at +2, resp_valid at +3, resp_fault=0.
REQ-024 SW addr 0x20, wdata 0xDEADBEEF -> mem_write at +1 with address 0x20; subsequent LW 0x20 returns 0xDEADBEEF.
REQ-025 LW addr 0x22, and SB addr 0x400 with MEM_WORDS=256 -> no memory strobe; resp_valid at +1 with resp_fault=1 and resp_rdata=0.
REQ-026 SB accepted, reset_n pulsed low during RMW_READ -> no mem_write, no resp_valid; outputs 0 immediately; req_ready=1 after release.
